// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings (shared with the ALU control decode) and FSM state type
// for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MD_DIVU  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_MULT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of either radix-2 shift-add multiply
// or restoring division on a 2*WIDTH-bit accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_mul,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_remSh;
    logic [WIDTH:0] w_diff;

    // Multiply keeps the multiplier in the low half and shifts the carry in from the top;
    // divide shifts the dividend into the partial remainder and appends a quotient bit.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_remSh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff  = w_remSh - {1'b0, i_opnd};
        if (i_mul) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_remSh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO.
// Define MDU_HILO_WRITE_EN to add the hiwrite/lowrite/wdata direct-write ports (MTHI/MTLO).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstart,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiloread,
    input  logic             hilosel,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_mul;
    logic               r_prodNeg;
    logic               r_remNeg;
    logic               r_divZero;
    logic               r_busy;
    logic               r_done;

    logic               w_isMul;
    logic               w_isSigned;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aAbs;
    logic [WIDTH-1:0]   w_bAbs;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_stepAcc;

    always_comb begin
        w_isMul    = 1'b0;
        w_isSigned = 1'b0;
        unique case (mdop)
            MD_MULT:  begin w_isMul = 1'b1; w_isSigned = 1'b1; end
            MD_MULTU: begin w_isMul = 1'b1; w_isSigned = 1'b0; end
            MD_DIV:   begin w_isMul = 1'b0; w_isSigned = 1'b1; end
            MD_DIVU:  begin w_isMul = 1'b0; w_isSigned = 1'b0; end
        endcase
        w_aNeg = w_isSigned & srca[WIDTH-1];
        w_bNeg = w_isSigned & srcb[WIDTH-1];
        w_aAbs = w_aNeg ? -srca : srca;
        w_bAbs = w_bNeg ? -srcb : srcb;
        w_prod = r_prodNeg ? -r_acc : r_acc;
        w_quot = r_prodNeg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_remNeg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mul  (r_mul),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_stepAcc)
    );

    // A new start always wins, even over an in-flight op or a direct write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mul     <= 1'b0;
            r_prodNeg <= 1'b0;
            r_remNeg  <= 1'b0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (mdstart) begin
                r_state   <= RUN;
                r_busy    <= 1'b1;
                r_count   <= CW'(WIDTH - 1);
                r_mul     <= w_isMul;
                r_opnd    <= w_isMul ? w_aAbs : w_bAbs;
                r_acc     <= {{WIDTH{1'b0}}, (w_isMul ? w_bAbs : w_aAbs)};
                r_prodNeg <= w_aNeg ^ w_bNeg;
                r_remNeg  <= w_aNeg;
                r_divZero <= !w_isMul && (srcb == '0);
`ifdef MDU_HILO_WRITE_EN
            end else if (hiwrite || lowrite) begin
                if (hiwrite) r_hi <= wdata;
                if (lowrite) r_lo <= wdata;
                r_state <= IDLE;
                r_busy  <= 1'b0;
`endif
            end else begin
                unique case (r_state)
                    RUN: begin
                        r_acc <= w_stepAcc;
                        if (r_count == '0) begin
                            r_state <= FIX;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    FIX: begin
                        // On divide-by-zero the remainder path holds |a| with a's own sign, i.e. srca.
                        if (r_mul) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_divZero) begin
                            r_hi <= w_rem;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign hilo_out = hilosel ? r_hi : r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign stall    = hiloread & r_busy;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the combinational ALU/shifter control decode, which issues `mdstart` and a 2-bit op code. The unit executes MULT/MULTU/DIV/DIVU over WIDTH iterations, holds results in HI/LO, and raises `stall` when the pipeline reads HI/LO before the result is ready.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; must be 8 or greater.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `mdstart`  in  1  one-cycle start request; samples `mdop`, `srca` and `srcb`.
- `mdop`  in  2  bit0 = 1 for multiply, 0 for divide; bit1 = 1 for signed. 11 MULT, 01 MULTU, 10 DIV, 00 DIVU.
- `srca`  in  WIDTH  multiplicand or dividend.
- `srcb`  in  WIDTH  multiplier or divisor.
- `hiloread`  in  1  the pipeline is reading HI/LO this cycle.
- `hilosel`  in  1  1 selects HI, 0 selects LO, for `hilo_out`.
- `hilo_out`  out  WIDTH  selected register; combinational from `hilosel`.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO are updated.
- `stall`  out  1  equals `hiloread & busy`.

## Operation
- Reset values: HI = 0, LO = 0, state IDLE, `busy` 0, `done` 0, iteration counter 0.
- States and transitions:
  - IDLE -> RUN on `mdstart`.
  - RUN -> RUN while the counter is not 0; the counter decrements each cycle.
  - RUN -> FIX when the counter is 0.
  - FIX -> IDLE.
- Start:
  - Latch absolute values of the operands when signed, raw values otherwise.
  - Latch the result sign: product or quotient sign = a[MSB] ^ b[MSB]; remainder sign = a[MSB]. Both signs are 0 for unsigned ops.
  - Load the counter with WIDTH-1.
- Multiply:
  - Radix-2 shift-add, one bit per cycle.
  - 2*WIDTH-bit accumulator.
  - HI holds the upper word, LO the lower word.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
- FIX:
  - Two's-complement negate the product, quotient or remainder according to the latched signs.
  - Write HI and LO.
- Divide by zero, signed or unsigned: LO = all ones, HI = `srca` as sampled. Sign fixup is bypassed.
- Signed most-negative / -1: LO = most-negative value, HI = 0. This falls out of the datapath; no special case is needed.
- `mdstart` while `busy`: abort the in-flight op and restart with the new operands. HI/LO are untouched by the aborted op.
- `reset` in any state: return to the reset values on that edge. A partial result is never written.
- HI/LO change only on the FIX edge (or a direct write, see Configuration).

## Timing
- Edge 0 samples `mdstart`.
- Iterations occur on edges 1..WIDTH.
- HI/LO are written on edge WIDTH+1.
- `busy` is high for WIDTH+1 cycles, from after edge 0 through edge WIDTH+1. With WIDTH=32 this is 33 cycles.
- `done` is high for exactly the one cycle after edge WIDTH+1.
- A back-to-back `mdstart` in the `done` cycle is accepted with no bubble.
- `stall` is combinational, and releases in the cycle `busy` falls. `hilo_out` in that cycle shows the new result.

## Configuration
- `MDU_HILO_WRITE_EN` defined:
  - Adds ports `hiwrite` (in, 1), `lowrite` (in, 1) and `wdata` (in, WIDTH), providing MTHI/MTLO.
  - A write lands on the next edge.
  - A write while `busy` aborts the in-flight op and returns to IDLE.
  - `mdstart` in the same cycle as a write takes priority, and the write is dropped.
  - `hiwrite` and `lowrite` together write both registers.
- Not defined: those ports are absent, and HI/LO are writable only by operation completion.

## Structure
- Shared package `mdu_pkg` holds:
  - Op encodings: `MD_DIVU`=2'b00, `MD_MULTU`=2'b01, `MD_DIV`=2'b10, `MD_MULT`=2'b11. These must match the decoder's mult/div encodings.
  - The state enum: IDLE, RUN, FIX.
- One sub-module, `mdu_step`: combinational single-iteration datapath.
  - Inputs: mode, accumulator, divisor/multiplicand.
  - Outputs: next accumulator.
- FSM, counter, sign latch and HI/LO live in `mdu_iter`.

## Test plan
All scenarios use WIDTH=32.
- MULT, `srca`=0xFFFFFFFD (-3), `srcb`=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` high for 1 cycle.
- MULTU, 0xFFFFFFFF by 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV, -7 by 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV, 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, 100 by 0 -> LO=0xFFFFFFFF, HI=0x00000064.
- Abort: MULTU 9*9, then at busy cycle 10 start MULTU 3*5 -> no intermediate HI/LO update; 33 cycles later HI=0, LO=15.
- Stall: `hiloread`=1 throughout an op -> `stall`=1 for exactly 33 cycles.
- Reset: `reset` asserted mid-RUN -> HI=LO=0 and `busy`=0 next cycle.
- With `MDU_HILO_WRITE_EN`: `hiwrite` with `wdata`=0x1234 during busy -> HI=0x1234, `busy`=0, no `done`.
